cpu_debug_scan_bridge: RTL
==========================

// Module: cpu_debug_scan_bridge
// PURPOSE
//  Parametrised successor to the CPU debug-module scan wrapper. Sits between the virtual-JTAG
//  strobes (already resynchronised into clk) and the CPU debug core. Supports N channels, each
//  with a capture word. A shifted data register (DR) of width DR_WIDTH is committed on update
//  as a {chan, data} command into a small FIFO. The core drains the FIFO with valid/ready
//  instead of the fixed take_action_* pulses.
// PARAMETERS
//  DR_WIDTH        38  shift/data register width, >= 2
//  IR_WIDTH        2   instruction register width, >= 2
//  NUM_CHAN        4   channels in use, 1..2**IR_WIDTH
//  CMD_FIFO_DEPTH  4   command FIFO entries, power of 2, >= 2
// PORTS
//  clk           in   1                   system clock, single domain
//  reset         in   1                   synchronous, active-high
//  scan_ir_in    in   IR_WIDTH            current IR value, sampled on scan_uir
//  scan_uir      in   1                   update-IR strobe, 1 clk pulse
//  scan_cdr      in   1                   capture-DR strobe, 1 clk pulse
//  scan_sdr      in   1                   shift-DR strobe, 1 clk pulse per bit
//  scan_udr      in   1                   update-DR strobe, 1 clk pulse
//  scan_tdi      in   1                   serial in, valid with scan_sdr
//  scan_tdo      out  1                   serial out, = sr[0]
//  scan_ir_out   out  IR_WIDTH            {0.., fifo_nonempty, overflow}
//  capture_data  in   NUM_CHAN*DR_WIDTH   per-channel capture words, chan c at [c*DR_WIDTH +: DR_WIDTH]
//  cmd_valid     out  1                   FIFO head valid
//  cmd_ready     in   1                   consumer accepts head
//  cmd_chan      out  IR_WIDTH            head channel
//  cmd_data      out  DR_WIDTH            head data (jdo equivalent)
//  err_clr       in   1                   clears sticky error flags
//  overflow      out  1                   sticky: update dropped because FIFO full
// BEHAVIOUR
//  - Reset (sync, high): ir_q=0, sr=0, FSM=IDLE, FIFO empty, cmd_valid=0, cmd_chan=0,
//    cmd_data=0, overflow=0, scan_tdo=0, len_err=0 (when built with the length check).
//  - Strobe priority, for illegal simultaneity only: uir > cdr > sdr > udr. A lower strobe in
//    the same cycle is ignored.
//  - scan_uir: ir_q <= scan_ir_in, FSM -> IDLE. An update in progress is abandoned.
//  - scan_cdr: sr <= capture_data word of ir_q, or all-zero if ir_q >= NUM_CHAN. FSM -> SHIFT.
//  - scan_sdr in SHIFT: sr <= {scan_tdi, sr[DR_WIDTH-1:1]}. scan_sdr in IDLE is ignored.
//  - scan_udr in SHIFT: FSM -> UPDATE. Next cycle, push {ir_q, sr} and FSM -> IDLE.
//  - The push is dropped if ir_q >= NUM_CHAN. scan_udr in IDLE is ignored.
//  - FSM states are IDLE / SHIFT / UPDATE.
//  - Latency: udr at cycle n -> cmd_valid high at n+2 if the FIFO was empty. No bypass.
//  - FIFO is first-word-fall-through with registered outputs. Pop = cmd_valid & cmd_ready.
//  - Full + pop + push in the same cycle: both occur and the push is accepted.
//  - Full + push without pop: push dropped, overflow <= 1. FIFO contents are unchanged.
//  - Empty + push + pop: cmd_ready is ignored while cmd_valid=0.
//  - Read/write pointers are log2(CMD_FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs
//    differ and low bits equal.
//  - err_clr clears overflow/len_err. If a set event occurs in the same cycle, set wins.
//  - scan_ir_out[0]=overflow, scan_ir_out[1]=cmd_valid, upper bits 0. Registered.
// CONFIGURATION
//  DEBUG_SCAN_LENCHK_EN defined:
//  - A shift counter is cleared on cdr and saturates at DR_WIDTH+1.
//  - On the UPDATE push, count != DR_WIDTH -> the command is dropped and sticky len_err <= 1.
//  - len_err is an extra 1-bit output placed after overflow.
//  - scan_ir_out[0] = overflow | len_err.
//  DEBUG_SCAN_LENCHK_EN undefined:
//  - No counter and no len_err port. Every in-range update is pushed regardless of shift count.
// TESTING
//  1. ir=1, cdr, chan1 capture=38'h2A_DEADBEEF; 38 sdr with tdi=0 -> tdo sequence = LSB-first
//     capture word.
//  2. ir=2, cdr, shift 38 bits of 38'h15_12345678 LSB-first, udr at cycle n, cmd_ready=1 ->
//     cmd_valid at n+2, chan=2, data=38'h15_12345678, one cycle.
//  3. cmd_ready=0, 5 updates with data 1..5 (DEPTH=4) -> overflow=1, ir_out[0]=1; drain gives
//     1,2,3,4; err_clr -> overflow=0.
//  4. FIFO full, update coincides with pop -> no overflow; drain order intact with 4 entries.
//  5. ir=3 with NUM_CHAN=3 -> capture shifts zeros, no push. uir mid-shift then udr -> no push.
//  6. LENCHK_EN: shift 37 bits then udr -> no push, len_err=1. Then 38 bits -> push,
//     len_err stays 1 until err_clr.

Source files
------------

// File: rtl/cpu_debug_scan_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_scan_bridge_if
// Brief    : Command-drain bus from the scan bridge FIFO to the CPU debug core.
// Revision : 1.0
// ============================================================================
interface cpu_debug_scan_bridge_if #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_chan;
    logic [DR_WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_chan, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_chan, input cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/cpu_debug_scan_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_scan_bridge
// Brief    : Virtual-JTAG DR scan to {chan,data} command FIFO bridge.
//            Optional shift-length check: DEBUG_SCAN_LENCHK_EN.
// Revision : 1.0
// ============================================================================
module cpu_debug_scan_bridge #(
    parameter int DR_WIDTH       = 38,
    parameter int IR_WIDTH       = 2,
    parameter int NUM_CHAN       = 4,
    parameter int CMD_FIFO_DEPTH = 4
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic [IR_WIDTH-1:0]          scan_ir_in,
    input  wire logic                         scan_uir,
    input  wire logic                         scan_cdr,
    input  wire logic                         scan_sdr,
    input  wire logic                         scan_udr,
    input  wire logic                         scan_tdi,
    output logic                              scan_tdo,
    output logic [IR_WIDTH-1:0]               scan_ir_out,
    input  wire logic [NUM_CHAN*DR_WIDTH-1:0] capture_data,
    cpu_debug_scan_bridge_if.master           cmd,
    input  wire logic                         err_clr,
    output logic                              overflow
`ifdef DEBUG_SCAN_LENCHK_EN
    ,
    output logic                              len_err
`endif
);
    localparam int PTR_W = $clog2(CMD_FIFO_DEPTH) + 1;
    localparam int AW    = PTR_W - 1;
    localparam int EW    = IR_WIDTH + DR_WIDTH;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_UPDATE = 2'd2} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IR_WIDTH-1:0] r_ir_q;
    logic [DR_WIDTH-1:0] r_sr;
    logic [DR_WIDTH-1:0] w_cap;
    logic [EW-1:0]       r_mem [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic                r_overflow;
    logic [IR_WIDTH-1:0] r_ir_out;
    logic                w_valid;
    logic                w_full;
    logic                w_pop;
    logic                w_chan_ok;
    logic                w_len_ok;
    logic                w_push_req;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_err_any;
    logic [EW-1:0]       w_head;

    // Strobe priority uir > cdr > sdr > udr
    logic w_cdr, w_sdr, w_udr;
    assign w_cdr = scan_cdr & ~scan_uir;
    assign w_sdr = scan_sdr & ~scan_uir & ~scan_cdr;
    assign w_udr = scan_udr & ~scan_uir & ~scan_cdr & ~scan_sdr;

    assign w_chan_ok = (32'(r_ir_q) < NUM_CHAN);

    always_comb begin
        w_cap = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (r_ir_q == IR_WIDTH'(c)) w_cap = capture_data[c*DR_WIDTH +: DR_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (scan_uir)                              w_state_nxt = ST_IDLE;
        else if (w_cdr)                            w_state_nxt = ST_SHIFT;
        else if (w_udr && r_state == ST_SHIFT)     w_state_nxt = ST_UPDATE;
        else if (r_state == ST_UPDATE)             w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_q <= '0;
            r_sr   <= '0;
        end else if (scan_uir) begin
            r_ir_q <= scan_ir_in;
        end else if (w_cdr) begin
            r_sr <= w_cap;
        end else if (w_sdr && r_state == ST_SHIFT) begin
            r_sr <= {scan_tdi, r_sr[DR_WIDTH-1:1]};
        end
    end

`ifdef DEBUG_SCAN_LENCHK_EN
    localparam int CW = $clog2(DR_WIDTH + 2);
    logic [CW-1:0] r_cnt;
    logic          r_len_err;
    logic          w_len_set;

    always_ff @(posedge clk) begin
        if (reset)                                                       r_cnt <= '0;
        else if (!scan_uir && w_cdr)                                     r_cnt <= '0;
        else if (w_sdr && r_state == ST_SHIFT && r_cnt != CW'(DR_WIDTH + 1)) r_cnt <= r_cnt + 1'b1;
    end

    assign w_len_ok  = (r_cnt == CW'(DR_WIDTH));
    assign w_len_set = (r_state == ST_UPDATE) && !scan_uir && w_chan_ok && !w_len_ok;

    always_ff @(posedge clk) begin
        if (reset)          r_len_err <= 1'b0;
        else if (w_len_set) r_len_err <= 1'b1;
        else if (err_clr)   r_len_err <= 1'b0;
    end

    assign len_err   = r_len_err;
    assign w_err_any = r_overflow | r_len_err;
`else
    assign w_len_ok  = 1'b1;
    assign w_err_any = r_overflow;
`endif

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign w_valid    = (r_wr_ptr != r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = w_valid & cmd.cmd_ready;
    assign w_push_req = (r_state == ST_UPDATE) && !scan_uir && w_chan_ok && w_len_ok;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < CMD_FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {r_ir_q, r_sr};
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          r_overflow <= 1'b0;
        else if (w_ovf_set) r_overflow <= 1'b1;
        else if (err_clr)   r_overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_out <= '0;
        end else begin
            r_ir_out    <= '0;
            r_ir_out[0] <= w_err_any;
            r_ir_out[1] <= w_valid;
        end
    end

    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign cmd.cmd_valid = w_valid;
    assign cmd.cmd_chan  = w_head[EW-1:DR_WIDTH];
    assign cmd.cmd_data  = w_head[DR_WIDTH-1:0];
    assign scan_tdo      = r_sr[0];
    assign scan_ir_out   = r_ir_out;
    assign overflow      = r_overflow;
endmodule
`default_nettype wire
